clock_time_adjust: RTL and testbench

Digital-clock timekeeping and time-set controller placed directly downstream of the push-button detectors. Each button input is the registered one-cycle rising-edge pulse from one detector instance. The block keeps hours, minutes and seconds running off a 1 Hz enable. A mode button switches it into an adjust state, where the other buttons select and change the hours or minutes field. Its outputs feed the display multiplexer.

---
 rtl/clock_pkg.sv | 15 +
 rtl/wrap_counter.sv | 43 ++++
 rtl/clock_time_adjust.sv | 125 ++++++++++++
 tb/tb_clock_time_adjust.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and widths for the digital-clock timekeeping and time-set controller.
package clock_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        ADJUST = 1'b1
    } state_e;

    localparam logic FIELD_MIN = 1'b0;
    localparam logic FIELD_HR  = 1'b1;

    localparam int HR_W = 5;
    localparam int MS_W = 6;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) up/down counter with synchronous clear; carry flags an increment applied at MAX.
module wrap_counter #(
    parameter int WIDTH = 6,
    parameter int MAX   = 59
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [WIDTH-1:0] value,
    output logic             carry
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // Simultaneous inc and dec cancel; clear wins over both.
    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc && !dec) begin
            value_d = (value_q == MAX_V) ? '0 : value_q + WIDTH'(1);
        end else if (dec && !inc) begin
            value_d = (value_q == '0) ? MAX_V : value_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign carry = inc && (value_q == MAX_V);

endmodule

// File: rtl/clock_time_adjust.sv
// Timekeeping and time-set controller: RUN counts hh:mm:ss on en_1hz, ADJUST edits hours/minutes.
//
// state  | meaning
// RUN    | time advances on en_1hz; left/right/up/down ignored
// ADJUST | time frozen; left/right pick field, up/down edit it; mode exits and clears seconds
module clock_time_adjust
    import clock_pkg::*;
#(
    parameter int HOURS_MAX = 23,
    parameter int MIN_MAX   = 59
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en_1hz,
    input  logic            btn_mode,
    input  logic            btn_left,
    input  logic            btn_right,
    input  logic            btn_up,
    input  logic            btn_down,
    output logic [HR_W-1:0] hours,
    output logic [MS_W-1:0] minutes,
    output logic [MS_W-1:0] seconds,
    output logic            adjust,
    output logic            field_sel
);

    state_e state_q;
    state_e state_d;
    logic   field_sel_q;
    logic   field_sel_d;

    logic run_tick;
    logic edit;
    logic up_only;
    logic dn_only;
    logic sec_clr;
    logic sec_carry;
    logic min_carry;
    logic hr_carry_unused;
    logic min_inc;
    logic min_dec;
    logic hr_inc;
    logic hr_dec;

    // Mode has priority in ADJUST: the exit cycle performs no edits.
    assign run_tick = (state_q == RUN) && en_1hz;
    assign edit     = (state_q == ADJUST) && !btn_mode;
    assign up_only  = btn_up && !btn_down;
    assign dn_only  = btn_down && !btn_up;
    assign sec_clr  = (state_q == ADJUST) && btn_mode;

    // Edits use the field selected before any toggle in the same cycle.
    assign min_inc = sec_carry || (edit && up_only && (field_sel_q == FIELD_MIN));
    assign min_dec = edit && dn_only && (field_sel_q == FIELD_MIN);
    assign hr_inc  = ((state_q == RUN) && min_carry)
                   || (edit && up_only && (field_sel_q == FIELD_HR));
    assign hr_dec  = edit && dn_only && (field_sel_q == FIELD_HR);

    always_comb begin
        state_d = state_q;
        if (btn_mode) begin
            state_d = (state_q == RUN) ? ADJUST : RUN;
        end
    end

    always_comb begin
        field_sel_d = field_sel_q;
        if (edit && (btn_left ^ btn_right)) begin
            field_sel_d = ~field_sel_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            field_sel_q <= FIELD_MIN;
        end else begin
            state_q     <= state_d;
            field_sel_q <= field_sel_d;
        end
    end

    wrap_counter #(
        .WIDTH (MS_W),
        .MAX   (MIN_MAX)
    ) u_seconds (
        .clk   (clk),
        .reset (reset),
        .inc   (run_tick),
        .dec   (1'b0),
        .clr   (sec_clr),
        .value (seconds),
        .carry (sec_carry)
    );

    wrap_counter #(
        .WIDTH (MS_W),
        .MAX   (MIN_MAX)
    ) u_minutes (
        .clk   (clk),
        .reset (reset),
        .inc   (min_inc),
        .dec   (min_dec),
        .clr   (1'b0),
        .value (minutes),
        .carry (min_carry)
    );

    wrap_counter #(
        .WIDTH (HR_W),
        .MAX   (HOURS_MAX)
    ) u_hours (
        .clk   (clk),
        .reset (reset),
        .inc   (hr_inc),
        .dec   (hr_dec),
        .clr   (1'b0),
        .value (hours),
        .carry (hr_carry_unused)
    );

    assign adjust    = (state_q == ADJUST);
    assign field_sel = field_sel_q;

endmodule

// File: tb/tb_clock_time_adjust.sv
// Directed bench for clock_time_adjust: counting, rollover, adjust editing, mode exit and reset.
module tb_clock_time_adjust;

    logic       clk;
    logic       reset;
    logic       en_1hz;
    logic       btn_mode;
    logic       btn_left;
    logic       btn_right;
    logic       btn_up;
    logic       btn_down;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       adjust;
    logic       field_sel;

    int n_checks = 0;
    int n_fail   = 0;
    logic [18:0] got;

    clock_time_adjust #(
        .HOURS_MAX (23),
        .MIN_MAX   (59)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en_1hz    (en_1hz),
        .btn_mode  (btn_mode),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .hours     (hours),
        .minutes   (minutes),
        .seconds   (seconds),
        .adjust    (adjust),
        .field_sel (field_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [18:0] pack(input int h, input int m, input int s, input int a, input int f);
        return {5'(h), 6'(m), 6'(s), 1'(a), 1'(f)};
    endfunction

    function automatic string fmt(input logic [18:0] v);
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        h = v[18:14];
        m = v[13:8];
        s = v[7:2];
        return $sformatf("%0d:%0d:%0d adj=%0d fs=%0d", h, m, s, v[1], v[0]);
    endfunction

    // One cycle of stimulus: applied at a falling edge, removed at the next; outputs valid then.
    task automatic step(input logic r, input logic m, input logic l, input logic rt,
                        input logic u, input logic d, input logic t);
        reset = r; btn_mode = m; btn_left = l; btn_right = rt;
        btn_up = u; btn_down = d; en_1hz = t;
        @(negedge clk);
        reset = 1'b0; btn_mode = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        btn_up = 1'b0; btn_down = 1'b0; en_1hz = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic ups(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_reset;
        step(1, 1, 0, 0, 1, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0);
        got = {hours, minutes, seconds, adjust, field_sel};
        n_checks++;
        if (got !== pack(0, 0, 0, 0, 0)) begin
            $display("FAIL reset_values: got %s required %s", fmt(got), fmt(pack(0, 0, 0, 0, 0)));
            n_fail++;
        end
    endtask

    task automatic test_run_count;
        step(1, 0, 0, 0, 0, 0, 0);
        ticks(59);
        got = {hours, minutes, seconds, adjust, field_sel};
        n_checks++;
        if (got !== pack(0, 0, 59, 0, 0)) begin
            $display("FAIL run_59_ticks: got %s required %s", fmt(got), fmt(pack(0, 0, 59, 0, 0)));
            n_fail++;
        end
        ticks(1);
        got = {hours, minutes, seconds, adjust, field_sel};
        n_checks++;
        if (got !== pack(0, 1, 0, 0, 0)) begin
            $display("FAIL run_60_ticks: got %s required %s", fmt(got), fmt(pack(0, 1, 0, 0, 0)));
            n_fail++;
        end
    endtask

    task automatic test_rollover;
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        got = {hours, minutes, seconds, adjust, field_sel};
        n_checks++;
        if (got !== pack(23, 59, 0, 1, 1)) begin
            $display("FAIL preload_down_wrap: got %s required %s", fmt(got), fmt(pack(23, 59, 0, 1, 1)));
            n_fail++;
        end
        step(0, 1, 0, 0, 0, 0, 0);
        ticks(59);
        got = {hours, minutes, seconds, adjust, field_sel};
        n_checks++;
        if (got !== pack(23, 59, 59, 0, 1)) begin
            $display("FAIL preload_235959: got %s required %s", fmt(got), fmt(pack(23, 59, 59, 0, 1)));
            n_fail++;
        end
        ticks(1);
        got = {hours, minutes, seconds, adjust, field_sel};
        n_checks++;
        if (got !== pack(0, 0, 0, 0, 1)) begin
            $display("FAIL day_rollover: got %s required %s", fmt(got), fmt(pack(0, 0, 0, 0, 1)));
            n_fail++;
        end
    endtask

    task automatic test_adjust_freeze;
        step(1, 0, 0, 0, 0, 0, 0);
        ticks(3);
        step(0, 1, 0, 0, 0, 0, 1);
        got = {hours, minutes, seconds, adjust, field_sel};
        n_checks++;
        if (got !== pack(0, 0, 4, 1, 0)) begin
            $display("FAIL mode_with_tick: got %s required %s", fmt(got), fmt(pack(0, 0, 4, 1, 0)));
            n_fail++;
        end
        step(0, 0, 0, 0, 0, 1, 0);
        ticks(5);
        got = {hours, minutes, seconds, adjust, field_sel};
        n_checks++;
        if (got !== pack(0, 59, 4, 1, 0)) begin
            $display("FAIL adjust_frozen: got %s required %s", fmt(got), fmt(pack(0, 59, 4, 1, 0)));
            n_fail++;
        end
    endtask

    task automatic test_field_edit;
        step(0, 0, 0, 1, 0, 0, 0);
        ups(23);
        got = {hours, minutes, seconds, adjust, field_sel};
        n_checks++;
        if (got !== pack(23, 59, 4, 1, 1)) begin
            $display("FAIL hours_up_23: got %s required %s", fmt(got), fmt(pack(23, 59, 4, 1, 1)));
            n_fail++;
        end
        ups(1);
        got = {hours, minutes, seconds, adjust, field_sel};
        n_checks++;
        if (got !== pack(0, 59, 4, 1, 1)) begin
            $display("FAIL hours_up_wrap: got %s required %s", fmt(got), fmt(pack(0, 59, 4, 1, 1)));
            n_fail++;
        end
        ups(1);
        step(0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 0, 0, 0);
        got = {hours, minutes, seconds, adjust, field_sel};
        n_checks++;
        if (got !== pack(1, 59, 4, 1, 1)) begin
            $display("FAIL up_down_left_right_cancel: got %s required %s", fmt(got), fmt(pack(1, 59, 4, 1, 1)));
            n_fail++;
        end
        step(0, 0, 1, 0, 1, 0, 0);
        got = {hours, minutes, seconds, adjust, field_sel};
        n_checks++;
        if (got !== pack(2, 59, 4, 1, 0)) begin
            $display("FAIL toggle_with_up: got %s required %s", fmt(got), fmt(pack(2, 59, 4, 1, 0)));
            n_fail++;
        end
        ups(1);
        got = {hours, minutes, seconds, adjust, field_sel};
        n_checks++;
        if (got !== pack(2, 0, 4, 1, 0)) begin
            $display("FAIL minutes_wrap_no_carry: got %s required %s", fmt(got), fmt(pack(2, 0, 4, 1, 0)));
            n_fail++;
        end
        step(0, 1, 0, 0, 0, 0, 0);
        got = {hours, minutes, seconds, adjust, field_sel};
        n_checks++;
        if (got !== pack(2, 0, 0, 0, 0)) begin
            $display("FAIL exit_clears_seconds: got %s required %s", fmt(got), fmt(pack(2, 0, 0, 0, 0)));
            n_fail++;
        end
    endtask

    task automatic test_mode_exit;
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        ups(10);
        step(0, 0, 1, 0, 0, 0, 0);
        ups(30);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        ticks(45);
        got = {hours, minutes, seconds, adjust, field_sel};
        n_checks++;
        if (got !== pack(10, 30, 45, 0, 0)) begin
            $display("FAIL run_ignores_buttons: got %s required %s", fmt(got), fmt(pack(10, 30, 45, 0, 0)));
            n_fail++;
        end
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        got = {hours, minutes, seconds, adjust, field_sel};
        n_checks++;
        if (got !== pack(10, 31, 0, 0, 0)) begin
            $display("FAIL set_103100: got %s required %s", fmt(got), fmt(pack(10, 31, 0, 0, 0)));
            n_fail++;
        end
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 1, 0, 0);
        got = {hours, minutes, seconds, adjust, field_sel};
        n_checks++;
        if (got !== pack(10, 31, 0, 0, 0)) begin
            $display("FAIL mode_priority: got %s required %s", fmt(got), fmt(pack(10, 31, 0, 0, 0)));
            n_fail++;
        end
    endtask

    task automatic test_reset_in_adjust;
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        ups(7);
        got = {hours, minutes, seconds, adjust, field_sel};
        n_checks++;
        if (got !== pack(7, 0, 0, 1, 1)) begin
            $display("FAIL adjust_hours_7: got %s required %s", fmt(got), fmt(pack(7, 0, 0, 1, 1)));
            n_fail++;
        end
        step(1, 1, 1, 0, 1, 0, 1);
        got = {hours, minutes, seconds, adjust, field_sel};
        n_checks++;
        if (got !== pack(0, 0, 0, 0, 0)) begin
            $display("FAIL reset_in_adjust: got %s required %s", fmt(got), fmt(pack(0, 0, 0, 0, 0)));
            n_fail++;
        end
        ticks(3);
        got = {hours, minutes, seconds, adjust, field_sel};
        n_checks++;
        if (got !== pack(0, 0, 3, 0, 0)) begin
            $display("FAIL count_after_reset: got %s required %s", fmt(got), fmt(pack(0, 0, 3, 0, 0)));
            n_fail++;
        end
    endtask

    initial begin
        reset = 1'b1; en_1hz = 1'b0; btn_mode = 1'b0; btn_left = 1'b0;
        btn_right = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        @(negedge clk);
        test_reset;
        test_run_count;
        test_rollover;
        test_adjust_freeze;
        test_field_edit;
        test_mode_exit;
        test_reset_in_adjust;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
